// File: rtl/riscv_pipeline_controller.sv
// riscv_pipeline_controller
//
// Central stall/flush sequencer for a 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
// It owns the per-stage valid bits and drives every pipeline-register enable.
// Three hazard sources are arbitrated with priority HALT > freeze > redirect > loaduse:
//   - freeze   : MEM stage is waiting on data memory
//   - redirect : taken branch / jump resolved in EX
//   - loaduse  : ID needs the result of a load still in EX
// A data-memory access frozen for MEM_TIMEOUT consecutive cycles parks the
// controller in HALT until reset. Two saturating performance counters track
// stall cycles and accepted redirects.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_rs1, id_rs2                  source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2        ID instruction actually reads rs1 / rs2
//   ex_rd, ex_is_load, ex_redirect  EX destination, load flag, branch taken / jump
//   mem_access, mem_ready           MEM is a load/store, data memory completes
//   pc_en .. mem_wb_en              pipeline-register enables (combinational)
//   pc_sel_redirect                 PC mux selects the EX target (combinational)
//   id_valid .. wb_valid            per-stage live-instruction flags (registered)
//   mem_timeout                     sticky error, controller is in HALT
//   stall_cycles, flush_count       saturating performance counters

module riscv_pipeline_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             pc_sel_redirect,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              WC_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } state_t;

    state_t          state, state_n;
    logic [WC_W-1:0] wcnt, wcnt_n;

    logic halted;
    logic freeze, redirect, loaduse;
    logic do_freeze, do_redirect, do_loaduse;

    // Raw hazard qualification, then resolve priority so that at most one of
    // the do_* terms is active. HALT masks everything.
    always_comb begin
        halted   = (state == ST_HALT);
        freeze   = mem_valid & mem_access & ~mem_ready;
        redirect = ex_valid & ex_redirect;
        loaduse  = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                    (id_uses_rs2 & (id_rs2 == ex_rd)));

        do_freeze   = ~halted & freeze;
        do_redirect = ~halted & ~freeze & redirect;
        do_loaduse  = ~halted & ~freeze & ~redirect & loaduse;
    end

    // Enables and PC select. A freeze still lets MEM/WB advance so a bubble
    // lands in WB instead of writing the register file twice. A redirect
    // proceeds with all enables high; the squash happens through the valids.
    always_comb begin
        pc_en           = 1'b1;
        if_id_en        = 1'b1;
        id_ex_en        = 1'b1;
        ex_mem_en       = 1'b1;
        mem_wb_en       = 1'b1;
        pc_sel_redirect = 1'b0;

        if (rst || halted) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (do_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (do_redirect) begin
            pc_sel_redirect = 1'b1;
        end else if (do_loaduse) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
        end
    end

    // Timeout FSM: wcnt counts consecutive frozen cycles on the current MEM
    // access. The MEM_TIMEOUT-th frozen cycle sees wcnt == MEM_TIMEOUT-1 and
    // the following edge enters HALT, which only reset leaves.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        case (state)
            ST_RUN: begin
                if (freeze) begin
                    state_n = ST_WAIT;
                    wcnt_n  = WC_ONE;
                end
            end
            ST_WAIT: begin
                if (freeze) begin
                    if (wcnt == WC_LAST) begin
                        state_n = ST_HALT;
                    end else begin
                        wcnt_n = wcnt + WC_ONE;
                    end
                end else begin
                    state_n = ST_RUN;
                    wcnt_n  = '0;
                end
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
            default: begin
                state_n = ST_RUN;
                wcnt_n  = '0;
            end
        endcase
    end

    // State register for the timeout FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
        end
    end

    // Valid-bit pipeline. On redirect the branch itself moves on to MEM while
    // the two younger slots are squashed; on load-use ID is held and a bubble
    // is inserted into EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
        end else if (halted) begin
            id_valid  <= id_valid;
        end else if (do_freeze) begin
            wb_valid  <= 1'b0;
        end else if (do_redirect) begin
            id_valid  <= 1'b0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b1;
            wb_valid  <= mem_valid;
        end else if (do_loaduse) begin
            ex_valid  <= 1'b0;
            mem_valid <= 1'b1;
            wb_valid  <= mem_valid;
        end else begin
            id_valid  <= 1'b1;
            ex_valid  <= id_valid;
            mem_valid <= ex_valid;
            wb_valid  <= mem_valid;
        end
    end

    // Saturating performance counters; nothing counts while halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((do_freeze || do_loaduse) && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (do_redirect && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

    assign mem_timeout = halted;

endmodule

// File: tb/tb_riscv_pipeline_controller.sv
// tb_riscv_pipeline_controller
//
// Directed testbench for riscv_pipeline_controller, built with a short
// timeout (4) and narrow counters (4 bits) so HALT and saturation are
// reachable quickly. Each test_* task drives its scenario and checks the
// hand-computed results inline.

module tb_riscv_pipeline_controller;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2;
    logic       id_uses_rs1, id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_is_load, ex_redirect;
    logic       mem_access, mem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       pc_sel_redirect;
    logic       id_valid, ex_valid, mem_valid, wb_valid;
    logic       mem_timeout;
    logic [3:0] stall_cycles, flush_count;

    logic [4:0] en;
    logic [3:0] vl;

    int n_cmp = 0;
    int n_bad = 0;

    assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    assign vl = {id_valid, ex_valid, mem_valid, wb_valid};

    riscv_pipeline_controller #(
        .MEM_TIMEOUT(4),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rd          (ex_rd),
        .ex_is_load     (ex_is_load),
        .ex_redirect    (ex_redirect),
        .mem_access     (mem_access),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .pc_sel_redirect(pc_sel_redirect),
        .id_valid       (id_valid),
        .ex_valid       (ex_valid),
        .mem_valid      (mem_valid),
        .wb_valid       (wb_valid),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0;
        ex_rd       = 5'd0;
        ex_is_load  = 1'b0;
        ex_redirect = 1'b0;
        mem_access  = 1'b0;
        mem_ready   = 1'b1;
    endtask

    // Reset, then four hazard-free cycles so every stage holds a live slot.
    task automatic reset_and_fill();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic set_loaduse_rs2(input logic [4:0] r);
        ex_is_load  = 1'b1;
        ex_rd       = r;
        id_rs2      = r;
        id_uses_rs2 = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #1;
        n_cmp++; if (en !== 5'b00000) begin n_bad++; $display("[TB] FAIL reset_cycle_en: got %b want %b", en, 5'b00000); end
        n_cmp++; if (pc_sel_redirect !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_cycle_pcsel: got %b want 0", pc_sel_redirect); end
        tick();
        n_cmp++; if (vl !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_valids: got %b want %b", vl, 4'b0000); end
        n_cmp++; if (stall_cycles !== 4'd0 || flush_count !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count); end
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_timeout: got %b want 0", mem_timeout); end
        rst = 1'b0;
        #1;
        n_cmp++; if (en !== 5'b11111) begin n_bad++; $display("[TB] FAIL fill_en: got %b want %b", en, 5'b11111); end
        tick();
        n_cmp++; if (vl !== 4'b1000) begin n_bad++; $display("[TB] FAIL fill_c1: got %b want %b", vl, 4'b1000); end
        tick();
        tick();
        n_cmp++; if (vl !== 4'b1110) begin n_bad++; $display("[TB] FAIL fill_c3: got %b want %b", vl, 4'b1110); end
        tick();
        n_cmp++; if (vl !== 4'b1111) begin n_bad++; $display("[TB] FAIL fill_c4: got %b want %b", vl, 4'b1111); end
        n_cmp++; if (stall_cycles !== 4'd0 || flush_count !== 4'd0) begin n_bad++; $display("[TB] FAIL fill_counters: got %0d/%0d want 0/0", stall_cycles, flush_count); end
    endtask

    task automatic test_loaduse();
        reset_and_fill();
        set_loaduse_rs2(5'd5);
        #1;
        n_cmp++; if (en !== 5'b00111) begin n_bad++; $display("[TB] FAIL loaduse_en: got %b want %b", en, 5'b00111); end
        tick();
        n_cmp++; if (vl !== 4'b1011) begin n_bad++; $display("[TB] FAIL loaduse_bubble: got %b want %b", vl, 4'b1011); end
        n_cmp++; if (stall_cycles !== 4'd1) begin n_bad++; $display("[TB] FAIL loaduse_stall: got %0d want 1", stall_cycles); end
        n_cmp++; if (en !== 5'b11111) begin n_bad++; $display("[TB] FAIL loaduse_one_bubble: got %b want %b", en, 5'b11111); end
        tick();
        n_cmp++; if (vl !== 4'b1101) begin n_bad++; $display("[TB] FAIL loaduse_after: got %b want %b", vl, 4'b1101); end
        // Destination x0 never creates a dependency.
        set_loaduse_rs2(5'd0);
        #1;
        n_cmp++; if (en !== 5'b11111) begin n_bad++; $display("[TB] FAIL loaduse_x0: got %b want %b", en, 5'b11111); end
        tick();
        n_cmp++; if (stall_cycles !== 4'd1) begin n_bad++; $display("[TB] FAIL loaduse_x0_stall: got %0d want 1", stall_cycles); end
        // rs2 matches but is not read: no stall. rs1 matches and is read: stall.
        clear_inputs();
        ex_is_load  = 1'b1;
        ex_rd       = 5'd7;
        id_rs2      = 5'd7;
        #1;
        n_cmp++; if (en !== 5'b11111) begin n_bad++; $display("[TB] FAIL loaduse_unused_rs2: got %b want %b", en, 5'b11111); end
        id_rs1      = 5'd7;
        id_uses_rs1 = 1'b1;
        #1;
        n_cmp++; if (en !== 5'b00111) begin n_bad++; $display("[TB] FAIL loaduse_rs1: got %b want %b", en, 5'b00111); end
        clear_inputs();
    endtask

    task automatic test_redirect_vs_loaduse();
        reset_and_fill();
        set_loaduse_rs2(5'd9);
        ex_redirect = 1'b1;
        #1;
        n_cmp++; if (pc_sel_redirect !== 1'b1) begin n_bad++; $display("[TB] FAIL redir_pcsel: got %b want 1", pc_sel_redirect); end
        n_cmp++; if (en !== 5'b11111) begin n_bad++; $display("[TB] FAIL redir_en: got %b want %b", en, 5'b11111); end
        tick();
        n_cmp++; if (vl !== 4'b0011) begin n_bad++; $display("[TB] FAIL redir_squash: got %b want %b", vl, 4'b0011); end
        n_cmp++; if (flush_count !== 4'd1) begin n_bad++; $display("[TB] FAIL redir_flush: got %0d want 1", flush_count); end
        n_cmp++; if (stall_cycles !== 4'd0) begin n_bad++; $display("[TB] FAIL redir_stall: got %0d want 0", stall_cycles); end
        clear_inputs();
    endtask

    task automatic test_mem_wait_redirect();
        reset_and_fill();
        mem_access  = 1'b1;
        mem_ready   = 1'b0;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (en !== 5'b00001) begin n_bad++; $display("[TB] FAIL wait_en[%0d]: got %b want %b", i, en, 5'b00001); end
            n_cmp++; if (pc_sel_redirect !== 1'b0) begin n_bad++; $display("[TB] FAIL wait_pcsel[%0d]: got %b want 0", i, pc_sel_redirect); end
            tick();
            n_cmp++; if (vl !== 4'b1110) begin n_bad++; $display("[TB] FAIL wait_valids[%0d]: got %b want %b", i, vl, 4'b1110); end
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (en !== 5'b11111 || pc_sel_redirect !== 1'b1) begin n_bad++; $display("[TB] FAIL wait_release: got en=%b sel=%b want en=11111 sel=1", en, pc_sel_redirect); end
        tick();
        n_cmp++; if (vl !== 4'b0011) begin n_bad++; $display("[TB] FAIL wait_redir_valids: got %b want %b", vl, 4'b0011); end
        n_cmp++; if (stall_cycles !== 4'd3 || flush_count !== 4'd1) begin n_bad++; $display("[TB] FAIL wait_counters: got %0d/%0d want 3/1", stall_cycles, flush_count); end
        n_cmp++; if (mem_timeout !== 1'b0) begin n_bad++; $display("[TB] FAIL wait_no_timeout: got %b want 0", mem_timeout); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        reset_and_fill();
        mem_access = 1'b1;
        mem_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (mem_timeout !== 1'b0 || en !== 5'b00001) begin n_bad++; $display("[TB] FAIL tmo_pre[%0d]: got tmo=%b en=%b want tmo=0 en=00001", i, mem_timeout, en); end
            tick();
        end
        #1;
        n_cmp++; if (mem_timeout !== 1'b1) begin n_bad++; $display("[TB] FAIL tmo_set: got %b want 1", mem_timeout); end
        n_cmp++; if (en !== 5'b00000) begin n_bad++; $display("[TB] FAIL tmo_en: got %b want %b", en, 5'b00000); end
        n_cmp++; if (stall_cycles !== 4'd4) begin n_bad++; $display("[TB] FAIL tmo_stall: got %0d want 4", stall_cycles); end
        // HALT ignores memory release and redirects.
        mem_ready   = 1'b1;
        ex_redirect = 1'b1;
        #1;
        n_cmp++; if (en !== 5'b00000 || pc_sel_redirect !== 1'b0) begin n_bad++; $display("[TB] FAIL halt_outputs: got en=%b sel=%b want en=00000 sel=0", en, pc_sel_redirect); end
        tick();
        n_cmp++; if (mem_timeout !== 1'b1 || vl !== 4'b1110) begin n_bad++; $display("[TB] FAIL halt_hold: got tmo=%b vl=%b want tmo=1 vl=1110", mem_timeout, vl); end
        n_cmp++; if (flush_count !== 4'd0 || stall_cycles !== 4'd4) begin n_bad++; $display("[TB] FAIL halt_counters: got %0d/%0d want 4/0", stall_cycles, flush_count); end
        rst = 1'b1;
        #1;
        n_cmp++; if (en !== 5'b00000) begin n_bad++; $display("[TB] FAIL halt_rst_en: got %b want %b", en, 5'b00000); end
        tick();
        rst = 1'b0;
        clear_inputs();
        #1;
        n_cmp++; if (mem_timeout !== 1'b0 || vl !== 4'b0000) begin n_bad++; $display("[TB] FAIL halt_cleared: got tmo=%b vl=%b want tmo=0 vl=0000", mem_timeout, vl); end
        n_cmp++; if (en !== 5'b11111 || stall_cycles !== 4'd0) begin n_bad++; $display("[TB] FAIL halt_run: got en=%b stall=%0d want en=11111 stall=0", en, stall_cycles); end
        tick();
        n_cmp++; if (vl !== 4'b1000) begin n_bad++; $display("[TB] FAIL halt_restart: got %b want %b", vl, 4'b1000); end
    endtask

    task automatic test_saturation();
        reset_and_fill();
        // Each load-use costs one bubble, then the held ID instruction refills
        // EX and stalls again: one stall every two cycles.
        set_loaduse_rs2(5'd3);
        repeat (28) tick();
        n_cmp++; if (stall_cycles !== 4'd14) begin n_bad++; $display("[TB] FAIL sat_14: got %0d want 14", stall_cycles); end
        repeat (2) tick();
        n_cmp++; if (stall_cycles !== 4'd15) begin n_bad++; $display("[TB] FAIL sat_15: got %0d want 15", stall_cycles); end
        repeat (10) tick();
        n_cmp++; if (stall_cycles !== 4'd15) begin n_bad++; $display("[TB] FAIL sat_hold: got %0d want 15", stall_cycles); end
        clear_inputs();
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        test_reset();
        test_loaduse();
        test_redirect_vs_loaduse();
        test_mem_wait_redirect();
        test_timeout();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_pipeline_controller.md
# riscv_pipeline_controller

Central stall/flush sequencer for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It owns the per-stage valid bits and drives every pipeline-register enable and flush. It arbitrates three hazard sources: data-memory wait states, taken branches/jumps resolved in EX (the `pcSrc`/`flush` result of branch resolution), and load-use dependencies. It also detects data-memory timeouts and keeps saturating stall/flush performance counters.

## Interface
- `MEM_TIMEOUT`, 16: consecutive frozen cycles allowed on one MEM access before HALT (≥2).
- `CNT_W`, 16: width of the performance counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_redirect`  in  1  EX branch taken or jump (pcSrc).
- `mem_access`  in  1  MEM instruction is a load/store.
- `mem_ready`  in  1  data memory completes this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register enables.
- `pc_sel_redirect`  out  1  PC mux selects the EX target.
- `id_valid`, `ex_valid`, `mem_valid`, `wb_valid`  out  1 each  stage holds a live instruction (registered).
- `mem_timeout`  out  1  sticky error; the controller is in HALT.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `pc_en`=0 outside HALT.
- `flush_count`  out  CNT_W  saturating count of accepted redirects.

## Operation
- **Qualified events** (combinational):
  - freeze = `mem_valid` & `mem_access` & !`mem_ready`.
  - redirect = `ex_valid` & `ex_redirect`.
  - loaduse = `ex_valid` & `ex_is_load` & (`ex_rd`≠0) & `id_valid` & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)).
- **Priority:** HALT > freeze > redirect > loaduse > normal.
- **Normal:** all enables 1. `id_valid`←1, `ex_valid`←`id_valid`, `mem_valid`←`ex_valid`, `wb_valid`←`mem_valid`.
- **Freeze:**
  - `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0; `id_valid`, `ex_valid`, `mem_valid` hold.
  - `mem_wb_en`=1 with `wb_valid`←0 (bubble into WB, so no register-file double write).
  - A redirect or loaduse pending during freeze is not acted on. EX is held, so it is re-evaluated after release.
- **Redirect:**
  - `pc_sel_redirect`=1; all enables 1.
  - `id_valid`←0 and `ex_valid`←0, which squashes the instructions in IF and ID.
  - `mem_valid`←1 (the branch proceeds).
  - `flush_count`+1.
- **Loaduse:**
  - `pc_en`=0, `if_id_en`=0; other enables 1.
  - `id_valid` holds; `ex_valid`←0 (bubble); `mem_valid`←1.
- **FSM states:**
  - RUN: on freeze → WAIT, with wcnt←1.
  - WAIT: freeze & wcnt==`MEM_TIMEOUT`−1 → HALT; freeze otherwise → WAIT, wcnt+1; no freeze → RUN, wcnt←0.
  - HALT: all enables 0, all valids hold, `pc_sel_redirect`=0, `mem_timeout`=1. Only `rst` exits.
- **Counters:**
  - `stall_cycles` increments on each freeze or loaduse cycle outside HALT.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- **Reset** (any cycle, including mid-WAIT or HALT), effective the next edge:
  - State RUN, wcnt 0, all valids 0, `mem_timeout` 0, both counters 0.
  - During the reset cycle every enable is 0 and `pc_sel_redirect` is 0.

## Timing
- All enables and `pc_sel_redirect` are combinational from current inputs and state, valid in the same cycle. There is no added latency.
- Valids, FSM state, wcnt and the counters are registered and update on the next rising edge.
- First valid ID instruction: `id_valid`=1 one cycle after `rst` deasserts; `wb_valid` follows 3 cycles later.
- Zero-wait memory (`mem_ready`=1 in the first MEM cycle) causes no stall.
- An N-cycle wait (N < `MEM_TIMEOUT`) freezes exactly N cycles, then resumes on the cycle `mem_ready`=1.
- HALT is entered on the edge ending the `MEM_TIMEOUT`-th consecutive frozen cycle. `mem_timeout` is 1 from the next cycle onward.
- Loaduse costs 1 bubble; redirect costs 2 squashed slots.

## Test plan
- **Reset fill:** deassert `rst` with no hazards. Expect `id_valid`=1 at cycle 1, `wb_valid`=1 at cycle 4, all enables 1, counters 0.
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1. Expect `pc_en`=`if_id_en`=0 for 1 cycle, `ex_valid`=0 next cycle, `stall_cycles`=1. Repeat with `ex_rd`=0: expect no stall.
- **Redirect vs loaduse:** assert both in one cycle. Expect `pc_sel_redirect`=1, `id_valid`=`ex_valid`=0 next, `flush_count`=1, `stall_cycles` unchanged.
- **Memory wait with redirect pending:** `mem_ready`=0 for 3 cycles while `ex_redirect`=1. Expect 3 frozen cycles with `pc_sel_redirect`=0 and `wb_valid`=0, then the redirect on the release cycle; `stall_cycles`=3, `flush_count`=1.
- **Timeout:** `MEM_TIMEOUT`=4, hold `mem_ready`=0. Expect `mem_timeout`=1 after 4 frozen cycles and all enables 0 while it holds. Then assert `rst`: expect `mem_timeout`=0 and RUN.
- **Saturation:** `CNT_W`=4, 20 loaduse cycles. Expect `stall_cycles`=15, not wrapped.
